// File: rtl/ofdm_preamble_sync.sv
// Preamble detector/aligner: finds a metric peak, delays samples DELAY beats and tags the
// sample just before the preamble start. Define OFDM_PREAMBLE_SYNC_HOLDOFF_EN for post-detection hold-off.
module ofdm_preamble_sync #(
  parameter int WIDTH_D      = 16,
  parameter int WIDTH_PHASE  = 32,
  parameter int WIDTH_GAIN   = 16,
  parameter int WIDTH_SAMPLE = 16,
  parameter int DELAY        = 512,
  parameter int PEAK_LAG     = 320,
  parameter int TIMEOUT      = 160,
  parameter int SR_THRESHOLD = 5,
  parameter int SR_PEAK_SHIFT = 6,
  parameter int SR_HOLDOFF   = 7
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic                                                   set_stb,
  input  logic [7:0]                                             set_addr,
  input  logic [31:0]                                            set_data,
  input  logic [2*WIDTH_SAMPLE+WIDTH_D+WIDTH_PHASE+WIDTH_GAIN-1:0] i_tdata,
  input  logic                                                   i_tvalid,
  output logic                                                   i_tready,
  output logic [2*WIDTH_SAMPLE-1:0]                              o_tdata,
  output logic [WIDTH_PHASE+WIDTH_GAIN-1:0]                      o_tuser,
  output logic                                                   o_tlast,
  output logic                                                   o_tvalid,
  input  logic                                                   o_tready,
  output logic [15:0]                                            det_count
);

  localparam int SW         = 2*WIDTH_SAMPLE;
  localparam int UW         = WIDTH_PHASE + WIDTH_GAIN;
  localparam int CNT_W      = $clog2(DELAY);
  localparam int LAG_W      = $clog2(TIMEOUT + 2) + 1;
  localparam int ALIGN_BASE = DELAY - PEAK_LAG - 2;

  typedef enum logic [1:0] {IDLE, TRACK, ALIGN, HOLDOFF} state_t;

  function automatic logic [WIDTH_D-1:0] drop_level(input logic [WIDTH_D-1:0] pk,
                                                    input logic [2:0] sh);
    logic [2:0] s;
    s = (sh == 3'd0) ? 3'd1 : sh;
    return pk - (pk >> s);
  endfunction

  function automatic logic [WIDTH_GAIN-1:0] gain_floor(input logic [WIDTH_GAIN-1:0] g);
    return (g == '0) ? WIDTH_GAIN'(1) : g;
  endfunction

  // Stage p0: input beat split and handshake
  logic [SW-1:0]          sample_p0;
  logic [WIDTH_D-1:0]     metric_p0;
  logic [WIDTH_PHASE-1:0] phase_p0;
  logic [WIDTH_GAIN-1:0]  gain_p0;
  logic                   vld_p0;
  logic                   primed;

  assign {sample_p0, metric_p0, phase_p0, gain_p0} = i_tdata;
  assign i_tready = o_tready || !primed;
  assign vld_p0   = i_tvalid && i_tready;

  logic [WIDTH_D-1:0] threshold;
  logic [2:0]         peak_shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      threshold  <= '1;
      peak_shift <= 3'd3;
    end else if (set_stb) begin
      if (set_addr == 8'(SR_THRESHOLD))  threshold  <= set_data[WIDTH_D-1:0];
      if (set_addr == 8'(SR_PEAK_SHIFT)) peak_shift <= set_data[2:0];
    end
  end

`ifdef OFDM_PREAMBLE_SYNC_HOLDOFF_EN
  logic [15:0] holdoff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        holdoff <= '0;
    else if (set_stb && set_addr == 8'(SR_HOLDOFF))   holdoff <= set_data[15:0];
  end
`endif

  logic unused_set;
  assign unused_set = ^set_data;

  // Delay line: write pointer doubles as the read address of sample n-DELAY
  logic [SW-1:0]    mem [DELAY];
  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W:0]   fill;
  logic [SW-1:0]    rd_sample;

  assign primed    = fill[CNT_W];
  assign rd_sample = mem[wr_ptr];

  always_ff @(posedge clk) begin
    if (vld_p0) mem[wr_ptr] <= sample_p0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (vld_p0) begin
      wr_ptr <= wr_ptr + CNT_W'(1);
      if (!primed) fill <= fill + (CNT_W+1)'(1);
    end
  end

  // Detection FSM and peak capture
  state_t                 state, state_nxt;
  logic [WIDTH_D-1:0]     max_q, max_nxt;
  logic [WIDTH_PHASE-1:0] pk_phase_q, pk_phase_nxt;
  logic [WIDTH_GAIN-1:0]  pk_gain_q, pk_gain_nxt;
  logic [LAG_W-1:0]       lag_q, lag_nxt;
  logic [CNT_W-1:0]       cnt_q, cnt_nxt;
  logic                   tag_p0;
`ifdef OFDM_PREAMBLE_SYNC_HOLDOFF_EN
  logic [15:0]            hcnt_q, hcnt_nxt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      max_q      <= '0;
      pk_phase_q <= '0;
      pk_gain_q  <= '0;
      lag_q      <= '0;
      cnt_q      <= '0;
`ifdef OFDM_PREAMBLE_SYNC_HOLDOFF_EN
      hcnt_q     <= '0;
`endif
    end else begin
      state      <= state_nxt;
      max_q      <= max_nxt;
      pk_phase_q <= pk_phase_nxt;
      pk_gain_q  <= pk_gain_nxt;
      lag_q      <= lag_nxt;
      cnt_q      <= cnt_nxt;
`ifdef OFDM_PREAMBLE_SYNC_HOLDOFF_EN
      hcnt_q     <= hcnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    max_nxt      = max_q;
    pk_phase_nxt = pk_phase_q;
    pk_gain_nxt  = pk_gain_q;
    lag_nxt      = lag_q;
    cnt_nxt      = cnt_q;
    tag_p0       = 1'b0;
`ifdef OFDM_PREAMBLE_SYNC_HOLDOFF_EN
    hcnt_nxt     = hcnt_q;
`endif
    if (vld_p0) begin
      case (state)
        IDLE: begin
          if (metric_p0 > threshold) begin
            state_nxt = TRACK;
            max_nxt   = '0;
            lag_nxt   = '0;
          end
        end
        TRACK: begin
          if (metric_p0 > max_q) begin
            max_nxt      = metric_p0;
            pk_phase_nxt = phase_p0;
            pk_gain_nxt  = gain_floor(gain_p0);
            lag_nxt      = '0;
          end else begin
            lag_nxt = lag_q + LAG_W'(1);
          end
          // lag equals beats since the peak, so the tag lands PEAK_LAG+1 samples before it
          if (metric_p0 < drop_level(max_nxt, peak_shift)) begin
            state_nxt = ALIGN;
            cnt_nxt   = CNT_W'(ALIGN_BASE) - CNT_W'(lag_nxt);
          end else if (lag_nxt > LAG_W'(TIMEOUT)) begin
            state_nxt = IDLE;
          end
        end
        ALIGN: begin
          if (cnt_q == '0) begin
            tag_p0 = 1'b1;
`ifdef OFDM_PREAMBLE_SYNC_HOLDOFF_EN
            if (holdoff == '0) begin
              state_nxt = IDLE;
            end else begin
              state_nxt = HOLDOFF;
              hcnt_nxt  = holdoff - 16'd1;
            end
`else
            state_nxt = IDLE;
`endif
          end else begin
            cnt_nxt = cnt_q - CNT_W'(1);
          end
        end
        HOLDOFF: begin
`ifdef OFDM_PREAMBLE_SYNC_HOLDOFF_EN
          if (hcnt_q == '0) state_nxt = IDLE;
          else              hcnt_nxt  = hcnt_q - 16'd1;
`else
          state_nxt = IDLE;
`endif
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stage p1: registered output, loaded only together with an accepted input once primed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_tvalid  <= 1'b0;
      o_tdata   <= '0;
      o_tlast   <= 1'b0;
      o_tuser   <= '0;
      det_count <= '0;
    end else if (vld_p0 && primed) begin
      o_tvalid <= 1'b1;
      o_tdata  <= rd_sample;
      o_tlast  <= tag_p0;
      o_tuser  <= tag_p0 ? {pk_phase_q, pk_gain_q} : UW'(0);
      if (tag_p0) det_count <= det_count + 16'd1;
    end else if (o_tready) begin
      o_tvalid <= 1'b0;
      o_tlast  <= 1'b0;
    end
  end

endmodule

// File: doc/ofdm_preamble_sync.md
# ofdm_preamble_sync

Parametrised preamble detector/aligner for the OFDM receive chain, placed after the plateau-correlation metric, phase and gain averaging stages. It consumes one aligned bundle per beat (sample, averaged D metric, phase, gain), detects a metric peak above a programmable threshold, and delays samples through a DELAY-deep line. It then emits the sample stream with tlast marking the sample immediately before the detected preamble start, and tuser carrying the phase and gain captured at the peak. Peak drop fraction, threshold and post-trigger hold-off are runtime-programmable.

## Interface
- WIDTH_D, 16: averaged D metric width, unsigned.
- WIDTH_PHASE, 32: phase width.
- WIDTH_GAIN, 16: gain width.
- WIDTH_SAMPLE, 16: I/Q component width (sc16 → 32-bit sample).
- DELAY, 512: sample delay line depth, power of 2, ≥ PEAK_LAG+TIMEOUT+2.
- PEAK_LAG, 320: samples from preamble start to metric peak.
- TIMEOUT, 160: max beats spent in TRACK before abandoning.
- SR_THRESHOLD, 5 / SR_PEAK_SHIFT, 6 / SR_HOLDOFF, 7: settings addresses.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- set_stb / set_addr / set_data  in  1/8/32  settings bus.
- i_tdata  in  2*WIDTH_SAMPLE+WIDTH_D+WIDTH_PHASE+WIDTH_GAIN  {sample, metric, phase, gain}, MSB first.
- i_tvalid / i_tready  in/out  1  input handshake.
- o_tdata  out  2*WIDTH_SAMPLE  delayed sample.
- o_tuser  out  WIDTH_PHASE+WIDTH_GAIN  {peak_phase, peak_gain}; valid when o_tlast=1.
- o_tlast / o_tvalid / o_tready  out/out/in  1  output handshake.
- det_count  out  16  detection counter, wraps.

## Operation
- Settings: threshold (WIDTH_D bits, reset all-ones = never detects); peak_shift (3 bits, reset 3; value 0 treated as 1); holdoff (16 bits, reset 0).
- Beat index n increments on every input handshake.
- Delay line: circular RAM, DELAY entries. Priming: the first DELAY beats after reset are accepted with o_tvalid=0. After that, input beat n is accepted only together with output of sample n−DELAY (i_tready = o_tready || !primed).
- States:
  - IDLE: metric > threshold (strict) → TRACK, with max cleared to 0 first.
  - TRACK: metric > max → capture max, phase, gain, peak index n_p; lag = 0. Otherwise lag+1. Then:
    - metric < max − (max >> peak_shift) → ALIGN, with countdown = n_p − PEAK_LAG − 1 + DELAY − n.
    - else lag > TIMEOUT → IDLE, no detection.
  - ALIGN: countdown decrements per input beat. The output beat whose sample index equals n_p−PEAK_LAG−1 carries o_tlast=1 and o_tuser={peak_phase,peak_gain}. det_count+1 on that beat. Then → HOLDOFF (macro on) or IDLE.
  - HOLDOFF: ignore metric for holdoff beats, then IDLE.
- Gain of 0 captured as 1.
- Settings writes take effect next cycle. A write during TRACK/ALIGN does not abort the current detection.
- Reset mid-operation: state IDLE, buffer emptied (re-prime), registers to reset values, all outputs 0.

## Timing
- Reset values: i_tready=1, o_tvalid=0, o_tlast=0, o_tdata=0, o_tuser=0, det_count=0.
- Outputs registered. o_tdata/o_tlast/o_tuser are held stable while o_tvalid && !o_tready.
- Input-to-output latency: exactly DELAY beats plus 1 clock.
- Full throughput: one beat per clock when o_tready=1.
- Decision (TRACK→ALIGN) is taken on the same beat that shows the drop. The countdown must reach its mark before the tagged sample leaves; DELAY constraint guarantees it.

## Configuration
- OFDM_PREAMBLE_SYNC_HOLDOFF_EN defined: HOLDOFF state and SR_HOLDOFF register present.
- Macro undefined: ALIGN → IDLE directly; writes to SR_HOLDOFF are ignored.

## Test plan
- Reset, threshold left at 0xFFFF, 2000 beats of metric 0x7FFF → no tlast, det_count=0, output = input delayed 512 beats.
- Threshold 0x1000, shift 3, metric ramps to peak 0x4000 at beat 900, falls below 0x3800 at beat 910 → single tlast on output sample 579, tuser = phase/gain of beat 900, det_count=1.
- Same stimulus with o_tready toggled 50% random → identical output sequence and tlast position, no lost or duplicated samples.
- Metric stays above threshold and flat for 200 beats → TIMEOUT abort, no tlast, next peak detected normally.
- Holdoff=400 (macro on), two peaks 300 beats apart → only the first is tagged. Macro off → both tagged.
- Assert reset during ALIGN → outputs 0 immediately, no tlast after release, re-prime takes 512 beats.
